drac_tile_reset_seq: RTL and testbench

//  Parametrised reset/wake-up sequencer for multi-hart Sargantana tiles in OpenPiton.

---
 rtl/drac_pkg.sv | 15 +
 rtl/drac_tile_reset_seq_if.sv | 27 ++
 rtl/drac_hart_rst_ctrl.sv | 94 +++++++++
 rtl/drac_tile_reset_seq.sv | 145 ++++++++++++++
 tb/tb_drac_tile_reset_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drac_pkg.sv
// Shared types and helpers for the Sargantana tile reset/wake-up sequencer.
package drac_pkg;

    typedef enum logic [1:0] {RESET, WAKE, RELEASE, IDLE} rst_seq_state_e;
    typedef enum logic [1:0] {OFF, RUN, DRAIN, HOLD} hart_rst_state_e;

    // Width of a saturating counter that must reach max(a, b); never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/drac_tile_reset_seq_if.sv
// Per-hart soft-reset handshake and status between a tile and its reset sequencer.
interface drac_tile_reset_seq_if #(
    parameter int NumHarts = 1
) ();
    import drac_pkg::*;

    // soft_rst_req_i[i] is a level held by the requester until soft_rst_ack_o[i]
    // pulses for one cycle; dropping it in that ack cycle prevents a repeat.
    logic [NumHarts-1:0] soft_rst_req_i;
    logic [NumHarts-1:0] soft_rst_ack_o;
    logic [NumHarts-1:0] mem_idle_i;
    logic [NumHarts-1:0] hart_running_o;
    logic [NumHarts-1:0] drain_timeout_o;
    rst_seq_state_e                 seq_state;
    hart_rst_state_e [NumHarts-1:0] hart_state;

    modport master (
        output soft_rst_req_i, mem_idle_i,
        input  soft_rst_ack_o, hart_running_o, drain_timeout_o, seq_state, hart_state
    );

    modport slave (
        input  soft_rst_req_i, mem_idle_i,
        output soft_rst_ack_o, hart_running_o, drain_timeout_o, seq_state, hart_state
    );

endinterface

// File: rtl/drac_hart_rst_ctrl.sv
// Per-hart reset controller: power-on release, then soft-reset drain/hold/ack cycles.
module drac_hart_rst_ctrl
    import drac_pkg::*;
#(
    parameter int SoftRstCycles = 16,
    parameter int DrainTimeout  = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            release_i,
    input  logic            soft_rst_req_i,
    input  logic            mem_idle_i,
    output hart_rst_state_e state_o,
    output logic            run_o,
    output logic            hold_o,
    output logic            running_o,
    output logic            ack_o,
    output logic            drain_timeout_o
);

    localparam int CntW = cnt_width(DrainTimeout, SoftRstCycles);
    localparam logic [CntW-1:0] DrainLast = CntW'((DrainTimeout > 0) ? DrainTimeout - 1 : 0);
    localparam logic [CntW-1:0] HoldLast  = CntW'((SoftRstCycles > 0) ? SoftRstCycles - 1 : 0);

    hart_rst_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic            tmo_q, tmo_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        tmo_d   = tmo_q;
        case (state_q)
            OFF: begin
                if (release_i) state_d = RUN;
            end
            RUN: begin
                if (soft_rst_req_i) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // An idle adapter wins over a timeout landing in the same cycle.
                if (mem_idle_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DrainLast) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HoldLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        state_o         = state_q;
        run_o           = (state_q == RUN) || (state_q == DRAIN);
        hold_o          = (state_q == HOLD);
        running_o       = (state_q == RUN);
        ack_o           = ack_q;
        drain_timeout_o = tmo_q;
    end

endmodule

// File: rtl/drac_tile_reset_seq.sv
// Tile reset/wake-up sequencer: synchronised reset, programmable wake delay,
// staggered per-hart release and per-hart soft-reset drain/hold.
module drac_tile_reset_seq
    import drac_pkg::*;
#(
    parameter int NumHarts      = 1,
    parameter int WakeCycles    = 32768,
    parameter int StaggerCycles = 8,
    parameter int SyncStages    = 2,
    parameter int SoftRstCycles = 16,
    parameter int DrainTimeout  = 1024
) (
    input  logic                clk_i,
    input  logic                reset_l,
    output logic                spc_grst_l,
    output logic [NumHarts-1:0] adapter_rst_no,
    output logic [NumHarts-1:0] hart_rst_no,
    output logic [NumHarts-1:0] hart_soft_rst_no,
    drac_tile_reset_seq_if.slave ctl
);

    localparam int CntW = cnt_width(WakeCycles, StaggerCycles);
    localparam int IdxW = (NumHarts > 1) ? $clog2(NumHarts) : 1;
    localparam logic [CntW-1:0] WakeLast  = CntW'(WakeCycles);
    localparam logic [CntW-1:0] StagLast  = CntW'(StaggerCycles);
    localparam logic [IdxW-1:0] LastHart  = IdxW'(NumHarts - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  rst_pre_n;
    logic                  rst_sync_n;

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) sync_q <= '0;
        else          sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end

    // The sequencing state leaves reset one stage ahead of rst_sync_n, so a hart
    // due at cycle 0 is already registered as RUN when rst_sync_n rises.
    assign rst_pre_n  = sync_q[SyncStages-2];
    assign rst_sync_n = sync_q[SyncStages-1];

    rst_seq_state_e      state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NumHarts-1:0] release_v;

    assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

    always_ff @(posedge clk_i or negedge rst_pre_n) begin
        if (!rst_pre_n) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            RESET, WAKE: begin
                if (cnt_q == WakeLast) begin
                    if ((NumHarts == 1) || (StaggerCycles == 0)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = CntW'(1);
                        idx_d   = IdxW'(1);
                    end
                end else begin
                    state_d = WAKE;
                    cnt_d   = cnt_inc;
                end
            end
            RELEASE: begin
                if (cnt_q == StagLast) begin
                    cnt_d = CntW'(1);
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == LastHart) state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // release_v[i] is asserted in the cycle before hart i must be out of reset.
    always_comb begin
        release_v = '0;
        case (state_q)
            RESET, WAKE: begin
                if (cnt_q == WakeLast) begin
                    release_v[0] = 1'b1;
                    if (StaggerCycles == 0) release_v = '1;
                end
            end
            RELEASE: begin
                for (int i = 0; i < NumHarts; i++) begin
                    if ((cnt_q == StagLast) && (idx_q == IdxW'(i))) release_v[i] = 1'b1;
                end
            end
            default: release_v = '0;
        endcase
    end

    hart_rst_state_e [NumHarts-1:0] hart_state;
    logic [NumHarts-1:0] hart_run, hart_hold, hart_running, hart_ack, hart_tmo;

    for (genvar g = 0; g < NumHarts; g++) begin : g_hart
        drac_hart_rst_ctrl #(
            .SoftRstCycles (SoftRstCycles),
            .DrainTimeout  (DrainTimeout)
        ) u_hart (
            .clk_i           (clk_i),
            .rst_ni          (rst_pre_n),
            .release_i       (release_v[g]),
            .soft_rst_req_i  (ctl.soft_rst_req_i[g]),
            .mem_idle_i      (ctl.mem_idle_i[g]),
            .state_o         (hart_state[g]),
            .run_o           (hart_run[g]),
            .hold_o          (hart_hold[g]),
            .running_o       (hart_running[g]),
            .ack_o           (hart_ack[g]),
            .drain_timeout_o (hart_tmo[g])
        );
    end

    assign spc_grst_l       = rst_sync_n;
    assign adapter_rst_no   = {NumHarts{rst_sync_n}} & ~hart_hold;
    assign hart_rst_no      = hart_run;
    assign hart_soft_rst_no = hart_run;

    assign ctl.soft_rst_ack_o  = hart_ack;
    assign ctl.hart_running_o  = hart_running;
    assign ctl.drain_timeout_o = hart_tmo;
    assign ctl.seq_state       = state_q;
    assign ctl.hart_state      = hart_state;

endmodule

// File: tb/tb_drac_tile_reset_seq.sv
// Directed bench for drac_tile_reset_seq: long wake, staggered release, soft reset flows, abort, zero wait.
module tb_drac_tile_reset_seq;
    import drac_pkg::*;

    int vectors     = 0;
    int miscompares = 0;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_a, rst_b, rst_c;

    // dut_a: 4 harts, wake 100, stagger 8
    drac_tile_reset_seq_if #(.NumHarts(4)) if_a ();
    logic       spc_a;
    logic [3:0] adp_a, hrst_a, hsrst_a;
    drac_tile_reset_seq #(
        .NumHarts(4), .WakeCycles(100), .StaggerCycles(8),
        .SyncStages(2), .SoftRstCycles(16), .DrainTimeout(1024)
    ) dut_a (
        .clk_i(clk_i), .reset_l(rst_a), .spc_grst_l(spc_a), .adapter_rst_no(adp_a),
        .hart_rst_no(hrst_a), .hart_soft_rst_no(hsrst_a), .ctl(if_a.slave)
    );

    // dut_b: single hart, default long wake
    drac_tile_reset_seq_if #(.NumHarts(1)) if_b ();
    logic       spc_b;
    logic [0:0] adp_b, hrst_b, hsrst_b;
    drac_tile_reset_seq #(
        .NumHarts(1), .WakeCycles(32768), .StaggerCycles(8),
        .SyncStages(2), .SoftRstCycles(16), .DrainTimeout(1024)
    ) dut_b (
        .clk_i(clk_i), .reset_l(rst_b), .spc_grst_l(spc_b), .adapter_rst_no(adp_b),
        .hart_rst_no(hrst_b), .hart_soft_rst_no(hsrst_b), .ctl(if_b.slave)
    );

    // dut_c: 4 harts, no wake, no stagger
    drac_tile_reset_seq_if #(.NumHarts(4)) if_c ();
    logic       spc_c;
    logic [3:0] adp_c, hrst_c, hsrst_c;
    drac_tile_reset_seq #(
        .NumHarts(4), .WakeCycles(0), .StaggerCycles(0),
        .SyncStages(2), .SoftRstCycles(16), .DrainTimeout(1024)
    ) dut_c (
        .clk_i(clk_i), .reset_l(rst_c), .spc_grst_l(spc_c), .adapter_rst_no(adp_c),
        .hart_rst_no(hrst_c), .hart_soft_rst_no(hsrst_c), .ctl(if_c.slave)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if ({spc_a, adp_a, hrst_a, hsrst_a} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_a_pins: got %b expected 0", {spc_a, adp_a, hrst_a, hsrst_a});
        end
        vectors++;
        if ({if_a.hart_running_o, if_a.soft_rst_ack_o, if_a.drain_timeout_o} !== 12'b0) begin
            miscompares++;
            $display("FAIL reset_a_status: got %b expected 0",
                     {if_a.hart_running_o, if_a.soft_rst_ack_o, if_a.drain_timeout_o});
        end
        vectors++;
        if ({spc_b, hrst_b, spc_c, hrst_c} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_bc_pins: got %b expected 0", {spc_b, hrst_b, spc_c, hrst_c});
        end
    endtask

    task automatic test_wake_long();
        rst_b = 1'b1;
        tick();
        vectors++;
        if (spc_b !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_long_grst_early: got %b expected 0", spc_b);
        end
        tick();
        vectors++;
        if (spc_b !== 1'b1 || hrst_b !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_long_grst: got grst=%b hrst=%b expected grst=1 hrst=0", spc_b, hrst_b);
        end
        repeat (32767) tick();
        vectors++;
        if (hrst_b !== 1'b0 || if_b.hart_running_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_long_before: got hrst=%b expected 0", hrst_b);
        end
        tick();
        vectors++;
        if (hrst_b !== 1'b1 || hsrst_b !== 1'b1 || if_b.hart_running_o !== 1'b1 || adp_b !== 1'b1) begin
            miscompares++;
            $display("FAIL wake_long_release: got hrst=%b srst=%b run=%b adp=%b expected 1111",
                     hrst_b, hsrst_b, if_b.hart_running_o, adp_b);
        end
    endtask

    // Releases dut_a from reset and follows cycles -1..130 against the stagger schedule.
    task automatic test_release();
        logic [3:0] exp_m;
        rst_a = 1'b1;
        for (int c = -1; c <= 130; c++) begin
            tick();
            for (int i = 0; i < 4; i++) exp_m[i] = (c >= 100 + 8 * i);
            vectors++;
            if (hrst_a !== exp_m || hsrst_a !== exp_m || if_a.hart_running_o !== exp_m) begin
                miscompares++;
                $display("FAIL release_c%0d: got hrst=%b srst=%b run=%b expected %b",
                         c, hrst_a, hsrst_a, if_a.hart_running_o, exp_m);
            end
            vectors++;
            if (spc_a !== (c >= 0) || adp_a !== ((c >= 0) ? 4'hF : 4'h0)) begin
                miscompares++;
                $display("FAIL release_grst_c%0d: got grst=%b adp=%b", c, spc_a, adp_a);
            end
            if (c == 124) begin
                vectors++;
                if (if_a.seq_state !== IDLE) begin
                    miscompares++;
                    $display("FAIL release_idle: got %0d expected %0d", if_a.seq_state, IDLE);
                end
            end
        end
    endtask

    task automatic test_soft_reset();
        if_a.soft_rst_req_i[1] = 1'b1;
        if_a.mem_idle_i[1]     = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            vectors++;
            if (if_a.hart_state[1] !== DRAIN || hrst_a !== 4'hF || adp_a !== 4'hF) begin
                miscompares++;
                $display("FAIL soft_drain_k%0d: got st=%0d hrst=%b adp=%b expected DRAIN 1111 1111",
                         k, if_a.hart_state[1], hrst_a, adp_a);
            end
        end
        if_a.mem_idle_i[1] = 1'b1;
        for (int h = 0; h < 16; h++) begin
            tick();
            vectors++;
            if (hrst_a !== 4'b1101 || hsrst_a !== 4'b1101 || adp_a !== 4'b1101 ||
                if_a.hart_running_o !== 4'b1101 || if_a.soft_rst_ack_o !== 4'b0) begin
                miscompares++;
                $display("FAIL soft_hold_h%0d: got hrst=%b srst=%b adp=%b run=%b ack=%b expected 1101x4 0000",
                         h, hrst_a, hsrst_a, adp_a, if_a.hart_running_o, if_a.soft_rst_ack_o);
            end
        end
        tick();
        vectors++;
        if (if_a.soft_rst_ack_o !== 4'b0010 || hrst_a !== 4'hF || adp_a !== 4'hF ||
            if_a.hart_running_o !== 4'hF || if_a.drain_timeout_o !== 4'h0) begin
            miscompares++;
            $display("FAIL soft_ack: got ack=%b hrst=%b adp=%b run=%b tmo=%b expected 0010 1111 1111 1111 0000",
                     if_a.soft_rst_ack_o, hrst_a, adp_a, if_a.hart_running_o, if_a.drain_timeout_o);
        end
        if_a.soft_rst_req_i[1] = 1'b0;
        tick();
        vectors++;
        if (if_a.soft_rst_ack_o !== 4'b0 || if_a.hart_state[1] !== RUN) begin
            miscompares++;
            $display("FAIL soft_after_ack: got ack=%b st=%0d expected 0000 RUN",
                     if_a.soft_rst_ack_o, if_a.hart_state[1]);
        end
    endtask

    // Harts 0 and 2 together, request kept high through the first ack.
    task automatic test_back_to_back();
        if_a.soft_rst_req_i = 4'b0101;
        tick();
        vectors++;
        if (if_a.hart_state[0] !== DRAIN || if_a.hart_state[2] !== DRAIN || if_a.hart_running_o !== 4'b1010) begin
            miscompares++;
            $display("FAIL b2b_drain: got st0=%0d st2=%0d run=%b expected DRAIN DRAIN 1010",
                     if_a.hart_state[0], if_a.hart_state[2], if_a.hart_running_o);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int h = 0; h < 16; h++) begin
                tick();
                vectors++;
                if (hrst_a !== 4'b1010 || adp_a !== 4'b1010 || hsrst_a !== 4'b1010) begin
                    miscompares++;
                    $display("FAIL b2b_hold_p%0d_h%0d: got hrst=%b adp=%b srst=%b expected 1010",
                             pass, h, hrst_a, adp_a, hsrst_a);
                end
            end
            tick();
            vectors++;
            if (if_a.soft_rst_ack_o !== 4'b0101 || if_a.hart_running_o !== 4'hF) begin
                miscompares++;
                $display("FAIL b2b_ack_p%0d: got ack=%b run=%b expected 0101 1111",
                         pass, if_a.soft_rst_ack_o, if_a.hart_running_o);
            end
            if (pass == 0) begin
                tick();
                vectors++;
                if (if_a.hart_state[0] !== DRAIN || if_a.hart_state[2] !== DRAIN || if_a.soft_rst_ack_o !== 4'b0) begin
                    miscompares++;
                    $display("FAIL b2b_repeat: got st0=%0d st2=%0d ack=%b expected DRAIN DRAIN 0000",
                             if_a.hart_state[0], if_a.hart_state[2], if_a.soft_rst_ack_o);
                end
                if_a.soft_rst_req_i = 4'b0000;
            end
        end
        tick();
        vectors++;
        if (if_a.soft_rst_ack_o !== 4'b0 || if_a.hart_running_o !== 4'hF) begin
            miscompares++;
            $display("FAIL b2b_done: got ack=%b run=%b expected 0000 1111", if_a.soft_rst_ack_o, if_a.hart_running_o);
        end
    endtask

    task automatic test_drain_timeout();
        if_a.mem_idle_i[3]     = 1'b0;
        if_a.soft_rst_req_i[3] = 1'b1;
        tick();
        if_a.soft_rst_req_i[3] = 1'b0;
        for (int k = 1; k <= 1024; k++) begin
            vectors++;
            if (if_a.hart_state[3] !== DRAIN || if_a.drain_timeout_o !== 4'b0) begin
                miscompares++;
                $display("FAIL tmo_drain_k%0d: got st=%0d tmo=%b expected DRAIN 0000",
                         k, if_a.hart_state[3], if_a.drain_timeout_o);
            end
            tick();
        end
        vectors++;
        if (if_a.hart_state[3] !== HOLD || if_a.drain_timeout_o !== 4'b1000 || hrst_a !== 4'b0111) begin
            miscompares++;
            $display("FAIL tmo_hold: got st=%0d tmo=%b hrst=%b expected HOLD 1000 0111",
                     if_a.hart_state[3], if_a.drain_timeout_o, hrst_a);
        end
        repeat (16) tick();
        vectors++;
        if (if_a.soft_rst_ack_o !== 4'b1000 || if_a.drain_timeout_o !== 4'b1000 || if_a.hart_running_o !== 4'hF) begin
            miscompares++;
            $display("FAIL tmo_ack: got ack=%b tmo=%b run=%b expected 1000 1000 1111",
                     if_a.soft_rst_ack_o, if_a.drain_timeout_o, if_a.hart_running_o);
        end
        tick();
        vectors++;
        if (if_a.soft_rst_ack_o !== 4'b0 || if_a.drain_timeout_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL tmo_sticky: got ack=%b tmo=%b expected 0000 1000", if_a.soft_rst_ack_o, if_a.drain_timeout_o);
        end
        if_a.mem_idle_i[3] = 1'b1;
    endtask

    task automatic test_reset_during_hold();
        if_a.soft_rst_req_i[1] = 1'b1;
        repeat (2) tick();
        if_a.soft_rst_req_i[1] = 1'b0;
        repeat (3) tick();
        vectors++;
        if (if_a.hart_state[1] !== HOLD) begin
            miscompares++;
            $display("FAIL abort_in_hold: got st=%0d expected HOLD", if_a.hart_state[1]);
        end
        rst_a = 1'b0;
        #1;
        vectors++;
        if ({spc_a, adp_a, hrst_a, hsrst_a} !== 13'b0 ||
            {if_a.hart_running_o, if_a.soft_rst_ack_o, if_a.drain_timeout_o} !== 12'b0) begin
            miscompares++;
            $display("FAIL abort_async: got pins=%b status=%b expected 0",
                     {spc_a, adp_a, hrst_a, hsrst_a},
                     {if_a.hart_running_o, if_a.soft_rst_ack_o, if_a.drain_timeout_o});
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if (if_a.soft_rst_ack_o !== 4'b0 || hrst_a !== 4'b0) begin
                miscompares++;
                $display("FAIL abort_no_ack_k%0d: got ack=%b hrst=%b expected 0000 0000",
                         k, if_a.soft_rst_ack_o, hrst_a);
            end
        end
        test_release();
    endtask

    task automatic test_zero_wait();
        rst_c = 1'b1;
        tick();
        vectors++;
        if (hrst_c !== 4'b0 || spc_c !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pre: got hrst=%b grst=%b expected 0000 0", hrst_c, spc_c);
        end
        tick();
        vectors++;
        if (hrst_c !== 4'hF || hsrst_c !== 4'hF || if_c.hart_running_o !== 4'hF || spc_c !== 1'b1 || adp_c !== 4'hF) begin
            miscompares++;
            $display("FAIL zero_c0: got hrst=%b srst=%b run=%b grst=%b adp=%b expected all 1",
                     hrst_c, hsrst_c, if_c.hart_running_o, spc_c, adp_c);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (if_c.hart_state[i] !== DRAIN) begin
                miscompares++;
                $display("FAIL zero_c1_drain%0d: got %0d expected %0d", i, if_c.hart_state[i], DRAIN);
            end
        end
        vectors++;
        if (if_c.hart_running_o !== 4'b0 || hrst_c !== 4'hF) begin
            miscompares++;
            $display("FAIL zero_c1: got run=%b hrst=%b expected 0000 1111", if_c.hart_running_o, hrst_c);
        end
        tick();
        vectors++;
        if (hrst_c !== 4'b0 || hsrst_c !== 4'b0 || adp_c !== 4'b0) begin
            miscompares++;
            $display("FAIL zero_c2_hold: got hrst=%b srst=%b adp=%b expected 0000", hrst_c, hsrst_c, adp_c);
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        if_a.soft_rst_req_i = '0;
        if_a.mem_idle_i     = '1;
        if_b.soft_rst_req_i = '0;
        if_b.mem_idle_i     = '1;
        if_c.soft_rst_req_i = '1;
        if_c.mem_idle_i     = '1;

        test_reset();
        test_wake_long();
        test_release();
        test_soft_reset();
        test_back_to_back();
        test_drain_timeout();
        test_reset_during_hold();
        test_zero_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
